// File: rtl/lmfe_pkg.sv
// rtl/lmfe_pkg.sv - shared pixel types and raster constants for the LMFE datapath
package lmfe_pkg;

    localparam int PIX_W = 8;
    localparam int IMG_W = 128;
    localparam int IMG_H = 128;

    typedef logic [PIX_W-1:0] lmfe_pix_t;

    typedef struct packed {
        logic      last;
        logic      eol;
        lmfe_pix_t pix;
    } lmfe_tagged_t;

endpackage

// File: rtl/lmfe_pos_cnt.sv
// rtl/lmfe_pos_cnt.sv - col/row raster position counter with end-of-row and end-of-frame tags
module lmfe_pos_cnt #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adv,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     eol,
    output logic                     last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    // Tags describe the current (pre-increment) position of the pixel being presented.
    assign eol  = (col == COL_W'(IMG_W - 1));
    assign last = eol && (row == ROW_W'(IMG_H - 1));

    // Advance one raster position per source pixel; wrap to (0,0) after the frame's last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (eol) begin
                col <= '0;
                if (last) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmfe_out_buf.sv
// rtl/lmfe_out_buf.sv - elastic FIFO between the median filter and the frame writer
module lmfe_out_buf #(
    parameter int DEPTH     = 16,
    parameter int IMG_W     = lmfe_pkg::IMG_W,
    parameter int IMG_H     = lmfe_pkg::IMG_H,
    parameter int AF_MARGIN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [lmfe_pkg::PIX_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [lmfe_pkg::PIX_W-1:0]   out_data,
    output logic                         out_eol,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
    output logic                         overflow
);

    import lmfe_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(DEPTH - AF_MARGIN);

    lmfe_tagged_t     mem [DEPTH];
    lmfe_tagged_t     head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_nxt;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             pos_eol;
    logic             pos_last;
    logic [$clog2(IMG_W)-1:0] pos_col;
    logic [$clog2(IMG_H)-1:0] pos_row;

    // Position tracks every source pixel, dropped or not, so tags stay on the source raster.
    lmfe_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos_cnt (
        .clk   (clk),
        .reset (reset),
        .adv   (in_valid),
        .col   (pos_col),
        .row   (pos_row),
        .eol   (pos_eol),
        .last  (pos_last)
    );

    assign full      = (level == LVL_FULL);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    // Fall-through head; forced to zero while empty so reset leaves clean outputs.
    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head.pix  : '0;
    assign out_eol  = out_valid ? head.eol  : 1'b0;
    assign out_last = out_valid ? head.last : 1'b0;

    // Occupancy after this cycle's push/pop; also feeds the registered almost_full.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (!push && pop) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage array carries no reset; validity is governed entirely by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{last: pos_last, eol: pos_eol, pix: in_data};
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level       <= level_nxt;
            almost_full <= (level_nxt >= LVL_AF);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lmfe_out_buf.sv
// tb/tb_lmfe_out_buf.sv - randomized self-checking bench for lmfe_out_buf against a queue model
module tb_lmfe_out_buf;

    localparam int DEPTH     = 16;
    localparam int IMG_W     = 128;
    localparam int IMG_H     = 128;
    localparam int AF_MARGIN = 4;
    localparam int LVL_W     = $clog2(DEPTH + 1);
    localparam int FRAME     = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_eol;
    logic             out_last;
    logic [LVL_W-1:0] level;
    logic             almost_full;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of {last, eol, pix}, linear pixel index within the frame, sticky drop flag.
    logic [9:0]  mq [$];
    int unsigned m_pos;
    bit          m_ovf;

    lmfe_out_buf #(
        .DEPTH     (DEPTH),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_eol     (out_eol),
        .out_last    (out_last),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pos = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        logic [9:0] h;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("out_data", 32'(out_data), 32'(h[7:0]));
            chk("out_eol", 32'(out_eol), 32'(h[8]));
            chk("out_last", 32'(out_last), 32'(h[9]));
        end
        chk("level", 32'(level), 32'(mq.size()));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - AF_MARGIN));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called at a negedge: check current outputs, drive one cycle of inputs, advance model and clock.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy);
        bit t_eol;
        bit t_last;
        check_outputs();
        in_valid  = v;
        in_data   = v ? d : 8'hxx;
        out_ready = rdy;
        if (mq.size() != 0 && rdy) begin
            void'(mq.pop_front());
        end
        if (v) begin
            t_eol  = ((m_pos % IMG_W) == IMG_W - 1);
            t_last = (m_pos == FRAME - 1);
            if (mq.size() < DEPTH) begin
                mq.push_back({t_last, t_eol, d});
            end else begin
                m_ovf = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm outputs clear without any clock edge.
    task automatic do_async_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_eol", 32'(out_eol), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, 8'h00, 1'b1);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        do_async_reset();

        // Pass-through of a full frame plus one, consumer always ready.
        for (int i = 0; i <= FRAME; i++) begin
            step(1'b1, 8'(i), 1'b1);
        end
        drain();

        // Fill to full, overflow with 0xAA, hold, then drain.
        do_async_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
        end
        step(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
        end
        drain();
        // Remaining pixels of row 0 start at col 17; eol must land on the 111th.
        for (int i = 0; i < IMG_W - DEPTH - 1; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
        end
        step(1'b1, 8'hC3, 1'b1);
        drain();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        do_async_reset();

        // Simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
        end
        step(1'b1, 8'h55, 1'b1);
        chk("full_pushpop_level", 32'(level), 32'(DEPTH));
        chk("full_pushpop_head", 32'(out_data), 32'h11);
        drain();

        // Alternating backpressure during streaming rows.
        do_async_reset();
        for (int i = 0; i < 2 * IMG_W; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'(i % 2 == 0));
        end
        drain();

        // Random traffic with varying producer/consumer rates.
        for (int i = 0; i < 4000; i++) begin
            int pv;
            int pr;
            pv = (i / 500) % 2 == 0 ? 70 : 40;
            pr = (i / 250) % 3 == 0 ? 30 : 65;
            step(1'($urandom_range(0, 99) < pv), 8'($urandom), 1'($urandom_range(0, 99) < pr));
        end
        drain();

        // Async reset with level 7 at row 3, col 40, then a row checked from (0,0).
        do_async_reset();
        for (int i = 0; i < 3 * IMG_W + 40 - 6; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
        end
        chk("pre_reset_level", 32'(level), 32'd7);
        do_async_reset();
        for (int i = 0; i < IMG_W + 2; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
        end
        drain();
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
